// File: rtl/drv_ad56x3.sv
// drv_ad56x3: dual-channel serial driver for AD5623/AD5643/AD5663-class DACs.
// Ports: clk, reset (async, active-high), ce strobe, dataA/dataB samples,
//        dacSync (active-low frame select), dacSclk, dacDin (MSB first).
// Each accepted ce sends frame A, a sync-high gap, then frame B.
// Frame B carries the update-all command.
module drv_ad56x3 #(
    parameter string SIGN_A        = "UNSIGNED",
    parameter string SIGN_B        = "UNSIGNED",
    parameter int    DATA_WIDTH    = 16,
    parameter int    SCLK_DIVIDER  = 2,
    parameter int    SYNC_DURATION = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] dataA,
    input  logic [DATA_WIDTH-1:0] dataB,
    output logic                  dacSync,
    output logic                  dacSclk,
    output logic                  dacDin
);

    localparam logic [2:0] COMMAND_WORD_A = 3'b000;
    localparam logic [2:0] ADDRESS_WORD_A = 3'b000;
    localparam logic [2:0] COMMAND_WORD_B = 3'b010;
    localparam logic [2:0] ADDRESS_WORD_B = 3'b001;

    localparam bit SGN_A = (SIGN_A == "SIGNED");
    localparam bit SGN_B = (SIGN_B == "SIGNED");

    localparam int SLOTS_MAX = (SYNC_DURATION > 24) ? SYNC_DURATION : 24;
    localparam int BIT_W     = $clog2(SLOTS_MAX);
    localparam int DIV_W     = (SCLK_DIVIDER > 2) ? $clog2(SCLK_DIVIDER) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIVIDER - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(SCLK_DIVIDER / 2);
    localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(23);
    localparam logic [BIT_W-1:0] GAP_LAST   = BIT_W'(SYNC_DURATION - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME_A,
        S_GAP,
        S_FRAME_B
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bit;
    logic [23:0]           r_shift;
    logic [23:0]           r_hold;
    logic                  r_sync;
    logic                  r_sclk;
    logic                  r_din;

    logic                  w_slot_end;
    logic                  w_frame;
    logic [DATA_WIDTH-1:0] w_offA;
    logic [DATA_WIDTH-1:0] w_offB;
    logic [15:0]           w_d16A;
    logic [15:0]           w_d16B;
    logic [23:0]           w_frameA;
    logic [23:0]           w_frameB;

    // Offset-binary conversion is just an MSB flip; samples are
    // left-justified into the 16-bit data field.
    always_comb begin
        w_offA = dataA;
        w_offB = dataB;
        w_offA[DATA_WIDTH-1] = dataA[DATA_WIDTH-1] ^ SGN_A;
        w_offB[DATA_WIDTH-1] = dataB[DATA_WIDTH-1] ^ SGN_B;
        w_d16A = 16'(w_offA) << (16 - DATA_WIDTH);
        w_d16B = 16'(w_offB) << (16 - DATA_WIDTH);
        w_frameA = {2'b00, COMMAND_WORD_A, ADDRESS_WORD_A, w_d16A};
        w_frameB = {2'b00, COMMAND_WORD_B, ADDRESS_WORD_B, w_d16B};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_slot_end = (r_div == DIV_LAST);
        w_frame    = (r_state == S_FRAME_A) || (r_state == S_FRAME_B);
        case (r_state)
            S_IDLE: begin
                if (ce) w_next = S_FRAME_A;
            end
            S_FRAME_A: begin
                if (w_slot_end && r_bit == FRAME_LAST) w_next = S_GAP;
            end
            S_GAP: begin
                if (w_slot_end && r_bit == GAP_LAST) w_next = S_FRAME_B;
            end
            S_FRAME_B: begin
                if (w_slot_end && r_bit == FRAME_LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_div walks through one bit slot; r_bit counts slots inside a
    // frame or the gap and restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_bit <= '0;
        end else if (r_state == S_IDLE || w_next != r_state) begin
            r_div <= '0;
            r_bit <= '0;
        end else if (w_slot_end) begin
            r_div <= '0;
            r_bit <= r_bit + BIT_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Frame B waits in r_hold until the gap ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_hold  <= '0;
        end else if (r_state == S_IDLE && ce) begin
            r_shift <= w_frameA;
            r_hold  <= w_frameB;
        end else if (r_state == S_GAP && w_next == S_FRAME_B) begin
            r_shift <= r_hold;
        end else if (w_frame && w_slot_end) begin
            r_shift <= {r_shift[22:0], 1'b0};
        end
    end

    // Pins are registered from the current state: they trail the FSM by
    // one cycle, so dacSync falls on the edge after the ce edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 1'b1;
            r_sclk <= 1'b1;
            r_din  <= 1'b0;
        end else begin
            r_sync <= !w_frame;
            r_sclk <= !w_frame || (r_div < DIV_HALF);
            r_din  <= w_frame && r_shift[23];
        end
    end

    assign dacSync = r_sync;
    assign dacSclk = r_sclk;
    assign dacDin  = r_din;

endmodule

// File: tb/tb_drv_ad56x3.sv
// tb_drv_ad56x3: directed bench for drv_ad56x3 (14-bit, A unsigned,
// B signed, divider 2, gap 5); frames captured on dacSclk falling edges.
module tb_drv_ad56x3;

    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic [DW-1:0] dataA = '0;
    logic [DW-1:0] dataB = '0;
    logic          dacSync;
    logic          dacSclk;
    logic          dacDin;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    drv_ad56x3 #(
        .SIGN_A("UNSIGNED"),
        .SIGN_B("SIGNED"),
        .DATA_WIDTH(DW),
        .SCLK_DIVIDER(2),
        .SYNC_DURATION(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .dataA(dataA),
        .dataB(dataB),
        .dacSync(dacSync),
        .dacSclk(dacSclk),
        .dacDin(dacDin)
    );

    logic [23:0] cap = '0;
    int          cap_n = 0;
    int          n_fall = 0;
    int          n_fall_hi = 0;
    logic [23:0] q_f[$];
    int          q_n[$];

    always @(negedge dacSclk) begin
        n_fall++;
        if (dacSync) begin
            n_fall_hi++;
        end else begin
            cap = {cap[22:0], dacDin};
            cap_n++;
        end
    end

    always @(posedge dacSync) begin
        if (cap_n > 0) begin
            q_f.push_back(cap);
            q_n.push_back(cap_n);
        end
        cap_n = 0;
    end

    function automatic logic [23:0] exp_frame(input bit chb,
                                              input logic [DW-1:0] s);
        int unsigned v;
        v = 32'(s);
        if (chb) v = (v + 8192) % 16384;
        v = v * 4;
        return {(chb ? 8'h11 : 8'h00), v[15:0]};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        dataA = a;
        dataB = b;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        dataA = ~a;
        dataB = ~b;
    endtask

    task automatic pop_frames(output int cnt,
                              output logic [23:0] fa, output logic [23:0] fb,
                              output int na, output int nb);
        cnt = q_f.size();
        fa = '0;
        fb = '0;
        na = 0;
        nb = 0;
        if (q_f.size() > 0) begin
            fa = q_f.pop_front();
            na = q_n.pop_front();
        end
        if (q_f.size() > 0) begin
            fb = q_f.pop_front();
            nb = q_n.pop_front();
        end
        q_f.delete();
        q_n.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_cmp++;
        if (dacSync !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_sync: got %b want 1", dacSync);
        end
        n_cmp++;
        if (dacSclk !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_sclk: got %b want 1", dacSclk);
        end
        n_cmp++;
        if (dacDin !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_din: got %b want 0", dacDin);
        end
        n_fall = 0;
        reset = 1'b0;
        tick(10);
        n_cmp++;
        if ({dacSync, dacSclk, dacDin} !== 3'b110) begin
            n_bad++;
            $display("FAIL post_rst_pins: got %b want 110",
                     {dacSync, dacSclk, dacDin});
        end
        n_cmp++;
        if (n_fall !== 0) begin
            n_bad++;
            $display("FAIL post_rst_edges: got %0d want 0", n_fall);
        end
    endtask

    task automatic test_known();
        logic [DW-1:0] va[4] = '{14'h3FFF, 14'h0000, 14'h1234, 14'h2AAA};
        logic [DW-1:0] vb[4] = '{14'h0000, 14'h2000, 14'h1FFF, 14'h3FFF};
        logic [23:0]   ea[4] = '{24'h00FFFC, 24'h000000, 24'h0048D0, 24'h00AAA8};
        logic [23:0]   eb[4] = '{24'h118000, 24'h110000, 24'h11FFFC, 24'h117FFC};
        int cnt, na, nb;
        logic [23:0] fa, fb;
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i]);
            tick(107);
            pop_frames(cnt, fa, fb, na, nb);
            n_cmp++;
            if (cnt !== 2) begin
                n_bad++;
                $display("FAIL known%0d_count: got %0d want 2", i, cnt);
            end
            n_cmp++;
            if (fa !== ea[i] || na !== 24) begin
                n_bad++;
                $display("FAIL known%0d_A: got %h/%0d want %h/24",
                         i, fa, na, ea[i]);
            end
            n_cmp++;
            if (fb !== eb[i] || nb !== 24) begin
                n_bad++;
                $display("FAIL known%0d_B: got %h/%0d want %h/24",
                         i, fb, nb, eb[i]);
            end
        end
    endtask

    task automatic test_timing();
        logic [23:0] fa_e = 24'h00FFFC;
        logic [23:0] fb_e = 24'h118000;
        logic        es, ek, ed;
        int cnt, na, nb;
        logic [23:0] fa, fb;
        send(14'h3FFF, 14'h0000);
        for (int t = 1; t <= 108; t++) begin
            tick();
            es = 1'b1;
            ek = 1'b1;
            ed = 1'b0;
            if (t >= 1 && t <= 48) begin
                es = 1'b0;
                ek = ((t - 1) % 2) == 0;
                ed = fa_e[23 - (t - 1) / 2];
            end else if (t >= 59 && t <= 106) begin
                es = 1'b0;
                ek = ((t - 59) % 2) == 0;
                ed = fb_e[23 - (t - 59) / 2];
            end
            n_cmp++;
            if ({dacSync, dacSclk, dacDin} !== {es, ek, ed}) begin
                n_bad++;
                $display("FAIL timing_k+%0d: got %b want %b",
                         t, {dacSync, dacSclk, dacDin}, {es, ek, ed});
            end
        end
        pop_frames(cnt, fa, fb, na, nb);
        n_cmp++;
        if (cnt !== 2 || fa !== fa_e || fb !== fb_e) begin
            n_bad++;
            $display("FAIL timing_frames: got %0d %h %h want 2 %h %h",
                     cnt, fa, fb, fa_e, fb_e);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pa, pb, a, b;
        int cnt, na, nb;
        logic [23:0] fa, fb;
        pa = '0;
        pb = '0;
        for (int i = 0; i < 4; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            send(a, b);
            if (i > 0) begin
                pop_frames(cnt, fa, fb, na, nb);
                n_cmp++;
                if (cnt !== 2 || fa !== exp_frame(1'b0, pa) ||
                    fb !== exp_frame(1'b1, pb) || na !== 24 || nb !== 24) begin
                    n_bad++;
                    $display("FAIL b2b%0d: got %0d %h %h want 2 %h %h",
                             i, cnt, fa, fb, exp_frame(1'b0, pa),
                             exp_frame(1'b1, pb));
                end
            end
            pa = a;
            pb = b;
            tick(106);
        end
        tick();
        pop_frames(cnt, fa, fb, na, nb);
        n_cmp++;
        if (cnt !== 2 || fa !== exp_frame(1'b0, pa) ||
            fb !== exp_frame(1'b1, pb)) begin
            n_bad++;
            $display("FAIL b2b_last: got %0d %h %h want 2 %h %h", cnt, fa,
                     fb, exp_frame(1'b0, pa), exp_frame(1'b1, pb));
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, b;
        int cnt, na, nb;
        logic [23:0] fa, fb;
        for (int i = 0; i < 5; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            send(a, b);
            tick(107);
            pop_frames(cnt, fa, fb, na, nb);
            n_cmp++;
            if (cnt !== 2 || fa !== exp_frame(1'b0, a) ||
                fb !== exp_frame(1'b1, b) || na !== 24 || nb !== 24) begin
                n_bad++;
                $display("FAIL rand%0d: got %0d %h %h want 2 %h %h", i, cnt,
                         fa, fb, exp_frame(1'b0, a), exp_frame(1'b1, b));
            end
        end
    endtask

    task automatic test_ignore_ce();
        int cnt, na, nb;
        logic [23:0] fa, fb;
        send(14'h0F0F, 14'h3C3C);
        tick(19);
        dataA = 14'h1111;
        dataB = 14'h2222;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick(39);
        dataA = 14'h3333;
        dataB = 14'h0444;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick(47);
        pop_frames(cnt, fa, fb, na, nb);
        n_cmp++;
        if (cnt !== 2 || fa !== 24'h003C3C || fb !== 24'h1170F0) begin
            n_bad++;
            $display("FAIL ignore_frames: got %0d %h %h want 2 003c3c 1170f0",
                     cnt, fa, fb);
        end
        tick(60);
        n_cmp++;
        if (q_f.size() !== 0 || dacSync !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_extra: got %0d frames sync %b want 0 1",
                     q_f.size(), dacSync);
        end
    endtask

    task automatic test_reset_mid();
        int cnt, na, nb;
        logic [23:0] fa, fb;
        send(14'h2468, 14'h1357);
        tick(70);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({dacSync, dacSclk, dacDin} !== 3'b110) begin
            n_bad++;
            $display("FAIL midrst_pins: got %b want 110",
                     {dacSync, dacSclk, dacDin});
        end
        tick(2);
        reset = 1'b0;
        q_f.delete();
        q_n.delete();
        cap_n = 0;
        tick(2);
        n_cmp++;
        if ({dacSync, dacSclk, dacDin} !== 3'b110) begin
            n_bad++;
            $display("FAIL midrst_idle: got %b want 110",
                     {dacSync, dacSclk, dacDin});
        end
        send(14'h0001, 14'h3FFE);
        tick(107);
        pop_frames(cnt, fa, fb, na, nb);
        n_cmp++;
        if (cnt !== 2 || fa !== 24'h000004 || fb !== 24'h117FF8 ||
            na !== 24 || nb !== 24) begin
            n_bad++;
            $display("FAIL midrst_frames: got %0d %h/%0d %h/%0d want 2 000004/24 117ff8/24",
                     cnt, fa, na, fb, nb);
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_timing();
        test_back_to_back();
        test_random();
        test_ignore_ce();
        test_reset_mid();
        n_cmp++;
        if (n_fall_hi !== 0) begin
            n_bad++;
            $display("FAIL sclk_fall_sync_high: got %0d want 0", n_fall_hi);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drv_ad56x3.md
# drv_ad56x3

Dual-channel serial driver for AD5623/AD5643/AD5663-class 2-channel DACs. On each `ce` strobe it latches one sample per channel and transmits two 24-bit SPI-style frames: channel A first, then channel B. Channel B's command also updates both DAC outputs simultaneously. It sits between the sample-rate datapath and the DAC pins, and includes per-channel signed-to-offset-binary conversion.

## Interface
- `SIGN_A`, default "UNSIGNED": "SIGNED" means `dataA` is two's complement and is converted to offset binary; any other value means straight binary.
- `SIGN_B`, default "UNSIGNED": same as `SIGN_A`, for `dataB`.
- `DATA_WIDTH`, default 16: sample width; legal range 1..16.
- `SCLK_DIVIDER`, default 2: `clk` cycles per `dacSclk` period; must be even and ≥2.
- `SYNC_DURATION`, default 5: `dacSync`-high gap between the two frames, in `dacSclk` periods; must be ≥1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  one-cycle sample strobe; starts a transfer.
- `dataA`  in  `DATA_WIDTH`  channel A sample; sampled only on the cycle `ce`=1.
- `dataB`  in  `DATA_WIDTH`  channel B sample; sampled only on the cycle `ce`=1.
- `dacSync`  out  1  active-low frame select (DAC SYNC).
- `dacSclk`  out  1  serial clock; the DAC samples `dacDin` on its falling edge.
- `dacDin`  out  1  serial data, MSB first.

## Operation
- Internal constants, visible by hierarchy to the bench:
  - `COMMAND_WORD_A`=3'b000: write input register.
  - `ADDRESS_WORD_A`=3'b000: DAC A.
  - `COMMAND_WORD_B`=3'b010: write input register, then update all.
  - `ADDRESS_WORD_B`=3'b001: DAC B.
- Frame layout, bits 23..0: `2'b00`, command[2:0], address[2:0], data16[15:0].
- data16 construction:
  - data16 = {sample MSB XOR s, sample[DATA_WIDTH-2:0], (16-DATA_WIDTH) zeros}.
  - s=1 when the channel's SIGN parameter is "SIGNED", otherwise 0.
  - Samples are left-justified.
- Both frames are built and latched on the `ce` cycle. Input changes afterwards have no effect.
- `ce` in IDLE is accepted. `ce` in any other state is ignored; the in-flight transfer is not disturbed.
- State machine:
  - IDLE → FRAME_A on accepted `ce`.
  - FRAME_A → GAP after 24 bit slots.
  - GAP → FRAME_B after `SYNC_DURATION`·`SCLK_DIVIDER` cycles.
  - FRAME_B → IDLE after 24 bit slots.
- Bit slot: `SCLK_DIVIDER` cycles. `dacSclk` is high for the first `SCLK_DIVIDER`/2 cycles and low for the rest. `dacDin` changes only at slot start, while `dacSclk` is high.
- `dacSync` is 0 in FRAME_A/FRAME_B and 1 in IDLE/GAP.
- `dacSclk` is held 1 in IDLE/GAP, so no falling edge ever occurs while `dacSync`=1.
- `dacDin` is 0 in IDLE/GAP.

## Timing
- Reset values: `dacSync`=1, `dacSclk`=1, `dacDin`=0, state IDLE, shift registers cleared.
- Reset asserted mid-transfer aborts immediately to the reset values. No partial-frame resume.
- Latency: `ce` sampled high at edge k → `dacSync` falls and `dacDin`=bit 23 of frame A at edge k+1.
- The first `dacSclk` falling edge occurs `SCLK_DIVIDER`/2 cycles after `dacSync` falls.
- FRAME_A: 24·`SCLK_DIVIDER` cycles. GAP: `SYNC_DURATION`·`SCLK_DIVIDER` cycles. FRAME_B: 24·`SCLK_DIVIDER` cycles.
- `dacSync` rises at the slot boundary after the 24th falling edge.
- Busy time from the `ce` edge back to IDLE: `SCLK_DIVIDER`·(48+`SYNC_DURATION`)+1 cycles. With defaults 2/5 this is 107.
- A new `ce` is accepted on the first IDLE cycle. A `ce` period of `SCLK_DIVIDER`·(48+`SYNC_DURATION`+1) cycles or more is always served.
- Exactly 24 `dacSclk` falling edges occur per `dacSync`-low window.

## Test plan
- Reset: hold `reset`, then release → `dacSync`=1, `dacSclk`=1, `dacDin`=0, and no `dacSclk` edges until `ce`.
- DATA_WIDTH=14, SIGN_A unsigned, SIGN_B signed, `dataA`=14'h3FFF, `dataB`=14'h0000 → shift out word A=24'h00FFFC and word B=24'h118000, sampling on `dacSclk` falling edges while `dacSync`=0.
- Same config, `dataA`=14'h0000, `dataB`=14'h2000 → word A=24'h000000, word B=24'h110000.
- SCLK_DIVIDER=2, SYNC_DURATION=5, `ce` at edge k → `dacSync` low from k+1 to k+49, high for 10 cycles, low for 48 cycles, then IDLE at k+107. Repeat with random data every 108 cycles and check every frame.
- `ce` pulsed again at edges k+20 and k+60 of an active transfer → ignored; frames are unchanged and no extra frame is sent.
- Assert `reset` during FRAME_B → outputs return to reset values asynchronously. After release, the next `ce` produces two correct, complete frames.
